// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage M-extension multiply/divide unit.
// Contents: FSM state type, the M-extension funct7 value, the funct3 codes
// handled by the unit, the iteration counter width, and a decode helper
// that says whether a {funct7, funct3} pair is one this unit executes.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL = 3'b000;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_REM = 3'b110;

  localparam int CNT_W = 5;

  // Only MUL, DIV and REM are executed here; every other encoding (MULH*,
  // DIVU, REMU, non-M funct7) leaves the unit idle.
  function automatic logic is_supported(input logic [9:0] funct);
    logic ok;
    ok = 1'b0;
    if (funct[9:3] == M_FUNCT7) begin
      case (funct[2:0])
        F3_MUL, F3_DIV, F3_REM: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem_i     - partial remainder so far (always < divisor_i)
//   divisor_i - unsigned divisor magnitude
//   bit_i     - next dividend bit, shifted into the remainder LSB
//   rem_o     - new partial remainder
//   q_o       - quotient bit produced by this step
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] divisor_i,
  input  logic        bit_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    // Two guard bits so the borrow out of the trial subtraction is clean
    // even when the shifted remainder needs 33 bits.
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    q_o     = ~diff[33];
    // rem_i < divisor_i guarantees the kept value fits in 32 bits.
    rem_o   = q_o ? diff[31:0] : shifted[31:0];
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M MUL / DIV / REM unit sitting in the EX stage.
// MUL is shift-add (low word only), DIV/REM is restoring division on
// operand magnitudes with sign fix-up at the end; both take 32 iterations.
// Divide-by-zero and the signed overflow case finish immediately.
//
// Handshake: the pipeline holds the instruction in ID/EX while busy_o is
// high. busy_o rises combinationally in the start cycle and stays high for
// the 32 iteration cycles; the following cycle done_o is high for exactly
// one cycle (longer only while mem_stall_i holds the pipeline) and EX/MEM
// captures result_o/rd_o on every clock edge where done_o is high and
// mem_stall_i is low. start_i is ignored while done_o is high.
//
// Ports:
//   clk_i, rst_i     - clock, synchronous active-low reset
//   start_i          - EX-stage instruction is an M-extension op
//   funct_i          - {funct7, funct3}
//   op_a_i, op_b_i   - rs1 / rs2 after forwarding
//   rd_i             - destination register
//   mem_stall_i      - data-memory stall, holds DONE
//   busy_o           - pipeline stall request
//   done_o           - result_o / rd_o valid
//   result_o, rd_o   - result and its destination register
//   dbg_state_o      - current FSM state, for observation only
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [9:0]  funct_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [4:0]  rd_i,
  input  logic        mem_stall_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o,
  output state_t      dbg_state_o
);

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q;
  // MUL: opa_q = shifting multiplicand, opb_q = shifting multiplier,
  //      acc_q = running product.
  // DIV: opa_q = dividend shifting out at the top / quotient shifting in
  //      at the bottom, opb_q = divisor magnitude, acc_q = remainder.
  logic [31:0]        opa_q, opb_q, acc_q;
  logic               is_rem_q, neg_q_q, neg_r_q;
  logic [31:0]        result_q;
  logic [4:0]         rd_q;

  logic        sup_start;
  logic [2:0]  f3;
  logic        is_div_op;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic        div_zero, div_ovf;
  logic        last_iter;
  logic [31:0] mul_next;
  logic [31:0] step_rem;
  logic        step_q;
  logic [31:0] quo_next;
  logic [31:0] div_result;

  always_comb begin
    sup_start = start_i && is_supported(funct_i);
    f3        = funct_i[2:0];
    is_div_op = (f3 != F3_MUL);
    a_neg     = op_a_i[31];
    b_neg     = op_b_i[31];
    // 32'h80000000 maps onto itself, which is the correct unsigned magnitude.
    abs_a     = a_neg ? (32'd0 - op_a_i) : op_a_i;
    abs_b     = b_neg ? (32'd0 - op_b_i) : op_b_i;
    div_zero  = (op_b_i == 32'd0);
    div_ovf   = (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
    last_iter = (cnt_q == '1);
    mul_next  = acc_q + (opb_q[0] ? opa_q : 32'd0);
  end

  div_step u_div_step (
    .rem_i     (acc_q),
    .divisor_i (opb_q),
    .bit_i     (opa_q[31]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    quo_next = {opa_q[30:0], step_q};
    if (is_rem_q) begin
      div_result = neg_r_q ? (32'd0 - step_rem) : step_rem;
    end else begin
      div_result = neg_q_q ? (32'd0 - quo_next) : quo_next;
    end
  end

  // Next-state and stall request.
  always_comb begin
    state_n = state_q;
    busy_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sup_start) begin
          busy_o = 1'b1;
          if (is_div_op && (div_zero || div_ovf)) state_n = ST_DONE;
          else if (is_div_op)                     state_n = ST_DIV;
          else                                    state_n = ST_MUL;
        end
      end
      ST_MUL: begin
        busy_o = 1'b1;
        if (last_iter) state_n = ST_DONE;
      end
      ST_DIV: begin
        busy_o = 1'b1;
        if (last_iter) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (!mem_stall_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_n;
      case (state_q)
        ST_IDLE: begin
          if (sup_start) begin
            rd_q     <= rd_i;
            cnt_q    <= '0;
            acc_q    <= '0;
            is_rem_q <= (f3 == F3_REM);
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            if (!is_div_op) begin
              opa_q <= op_a_i;
              opb_q <= op_b_i;
            end else begin
              opa_q <= abs_a;
              opb_q <= abs_b;
              // Early-exit cases produce their architectural result now.
              if (div_zero) begin
                result_q <= (f3 == F3_REM) ? op_a_i : 32'hFFFF_FFFF;
              end else if (div_ovf) begin
                result_q <= (f3 == F3_REM) ? 32'd0 : 32'h8000_0000;
              end
            end
          end
        end
        ST_MUL: begin
          acc_q <= mul_next;
          opa_q <= {opa_q[30:0], 1'b0};
          opb_q <= {1'b0, opb_q[31:1]};
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) result_q <= mul_next;
        end
        ST_DIV: begin
          acc_q <= step_rem;
          opa_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) result_q <= div_result;
        end
        default: ;
      endcase
    end
  end

  assign done_o      = (state_q == ST_DONE);
  assign result_o    = result_q;
  assign rd_o        = rd_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-low; sampled only on clk_i rising edge.
REQ-003 start_i  input  1  EX-stage instruction held in the ID/EX register is an M-extension op (funct7 = 7'b0000001, RegWrite set).
REQ-004 funct_i  input  10  {funct7, funct3} of the EX-stage instruction.
REQ-005 op_a_i  input  32  rs1 operand, post-forwarding.
REQ-006 op_b_i  input  32  rs2 operand, post-forwarding.
REQ-007 rd_i  input  5  destination register of the EX-stage instruction.
REQ-008 mem_stall_i  input  1  data-memory stall; pipeline frozen this cycle.
REQ-009 busy_o  output  1  stall request to PC, IF/ID and ID/EX.
REQ-010 done_o  output  1  result_o/rd_o valid; EX/MEM captures them this cycle.
REQ-011 result_o  output  32  MUL low word, DIV quotient or REM remainder.
REQ-012 rd_o  output  5  destination register latched at start.

Function
REQ-013 Supported funct3 with funct7 = 0000001: 000 MUL, 100 DIV (signed), 110 REM (signed); any other funct_i is "unsupported", never starts, busy_o stays 0.
REQ-014 States: IDLE, MUL, DIV, DONE; one-hot or binary encoding is free.
REQ-015 busy_o = 1 combinationally in IDLE when start_i and funct supported, and throughout MUL and DIV; 0 in DONE and otherwise.
REQ-016 IDLE + supported start: latch op_a_i, op_b_i, rd_i, op kind; clear 5-bit iteration count; go MUL (funct3 000) or DIV (100/110).
REQ-017 MUL: shift-add, one multiplier bit per cycle, 32 cycles; keep low 32 bits only (sign-agnostic).
REQ-018 DIV: restoring unsigned divide on |a|, |b|, one quotient bit per cycle, 32 cycles; quotient negated if sign(a) xor sign(b), remainder takes sign(a).
REQ-019 After iteration count 31 -> DONE; normal latency: busy_o high in start cycle plus 32 cycles, done_o high in cycle 33 after the start cycle.
REQ-020 Divide by zero (b = 0), detected at start: go directly to DONE; DIV result 32'hFFFFFFFF, REM result = a; done_o in cycle 1.
REQ-021 Overflow (a = 32'h80000000, b = 32'hFFFFFFFF), detected at start: go directly to DONE; DIV result 32'h80000000, REM result 0.
REQ-022 DONE: done_o = 1, result_o/rd_o stable; stay in DONE while mem_stall_i = 1; else next state IDLE.
REQ-023 start_i ignored in DONE (same instruction still visible); back-to-back M-ops start from IDLE the following cycle.
REQ-024 Iteration proceeds regardless of mem_stall_i; only DONE is held by it.
REQ-025 result_o, rd_o hold last value outside DONE; done_o = 0 outside DONE.

Reset
REQ-026 rst_i = 0 at a rising edge: state IDLE, count 0, busy_o 0, done_o 0, result_o 0, rd_o 0, operand/accumulator registers 0.
REQ-027 Reset mid-MUL/DIV or in DONE aborts the operation; no done_o pulse follows; the first cycle after release is IDLE.

Structure
REQ-028 Shared package muldiv_pkg holds: state typedef, M-extension funct7 constant, funct3 constants MUL/DIV/REM, iteration count width (5).
REQ-029 One sub-module div_step: combinational single restoring-division step (remainder, divisor, next dividend bit -> new remainder, quotient bit); instantiated once.
REQ-030 Total RTL 120-400 lines; no multiplier/divider operators (*, /, %) inferred.

Verification
REQ-031 MUL 7 x -3 (32'h00000007, 32'hFFFFFFFD), rd 5 -> busy 33 cycles, done_o at cycle 33, result 32'hFFFFFFEB, rd_o 5.
REQ-032 DIV -7 / 2 and REM -7 / 2 -> result 32'hFFFFFFFD and 32'hFFFFFFFF respectively, done at cycle 33.
REQ-033 DIV 100 / 0 and REM 100 / 0 -> done_o at cycle 1, results 32'hFFFFFFFF and 32'h00000064.
REQ-034 DIV 32'h80000000 / 32'hFFFFFFFF -> done_o at cycle 1, result 32'h80000000; REM same operands -> 0.
REQ-035 MUL with mem_stall_i = 1 for 3 cycles starting at DONE -> done_o high 4 cycles, result constant, start_i high throughout causes no restart.
REQ-036 rst_i low at cycle 10 of a DIV -> next cycle IDLE, busy_o 0, all outputs 0, no done_o; unsupported funct3 001 start -> busy_o never asserted.
